pc_fetch_sequencer: RTL
=======================

Name: pc_fetch_sequencer

Overview:
- Owns the program counter and sequences instruction fetch toward instruction memory using a valid/ready request and a response-valid return.
- Time-shares one 32-bit PC adder between sequential increment (PC+4) and redirect target computation (base+offset).
- Sits between the decode/branch logic, which supplies stall and redirect, and the instruction memory port.

Parameters:
- XLEN, 32, datapath and address width.
- RESET_VECTOR, 32'h0000_0000, PC value loaded on reset.
- PC_INC, 4, sequential increment added to the PC.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req_valid  out  1  fetch request valid.
- imem_req_ready  in  1  memory accepts the request.
- imem_addr  out  XLEN  fetch address; always equals the current PC.
- imem_rsp_valid  in  1  fetch data returned (data itself is not routed through this block).
- instr_valid  out  1  a fetched instruction is presented downstream.
- instr_pc  out  XLEN  PC of the presented instruction.
- stall  in  1  downstream cannot accept; holds the current instruction.
- redirect_valid  in  1  branch/jump taken this cycle.
- redirect_base  in  XLEN  target base (branch PC or rs1).
- redirect_offset  in  XLEN  sign-extended immediate.
- redirect_jalr  in  1  clear bit 0 of the computed target.
- misalign_err  out  1  one-cycle pulse when a redirect target is not 4-byte aligned.

Behaviour:
- Reset:
  - Asynchronous clear when rst_n=0.
  - pc=RESET_VECTOR, state=BOOT, kill=0.
  - imem_req_valid=0, instr_valid=0, instr_pc=0, misalign_err=0.
- Adder sharing:
  - One adder instance. Operands are (redirect_base, redirect_offset) when redirect_valid=1; otherwise (pc, PC_INC).
  - Sum wraps modulo 2^XLEN; no carry out.
  - jalr target = sum & ~1.
- State BOOT: one cycle after reset release -> REQ. All inputs ignored.
- State REQ:
  - imem_req_valid=1 and imem_addr=pc, both stable until handshake.
  - valid&ready -> WAIT.
- State WAIT:
  - imem_rsp_valid=1 with kill=0 -> OUT.
  - imem_rsp_valid=1 with kill=1 -> response discarded, kill<=0, -> REQ.
- State OUT:
  - instr_valid=1, instr_pc=pc.
  - stall=1: stay in OUT; outputs held.
  - stall=0: pc<=pc+PC_INC, -> REQ.
- Latency:
  - Response in cycle m gives instr_valid=1 in cycle m+1.
  - Back-to-back fetches with zero-wait memory issue one instruction every 3 cycles (REQ, WAIT, OUT).
- Redirect (any state except BOOT):
  - Has priority over stall and over increment.
  - If the computed target has bits[1:0] != 0 after jalr masking: misalign_err pulses the next cycle and the redirect is ignored entirely.
  - Otherwise pc<=target and:
    - REQ without handshake this cycle: stay REQ; the new address is presented next cycle. This is the only permitted change of imem_addr while valid.
    - REQ with handshake in the same cycle: -> WAIT with kill=1.
    - WAIT with no response: kill<=1.
    - WAIT with response in the same cycle: response discarded, -> REQ.
    - OUT: instr_valid drops next cycle, -> REQ.
- imem_rsp_valid outside WAIT is ignored.
- Reset mid-operation aborts any outstanding request. A stale response arriving after reset is ignored because it does not arrive in WAIT.
- Wrap-around: pc=32'hFFFF_FFFC with increment -> 32'h0000_0000, no error.

Decomposition:
- Shared package/header pc_fetch_pkg:
  - state encoding BOOT=0, REQ=1, WAIT=2, OUT=3 (2-bit);
  - XLEN, PC_INC, RESET_VECTOR defaults.
- Sub-module pc_add32: purely combinational A+B -> sum, XLEN wide.
  - The sequencer instantiates exactly one of these and muxes its operands.

Test Plan:
- Reset then zero-wait memory (ready=1, rsp one cycle after handshake), no stall -> imem_addr sequence 0x0, 0x4, 0x8; instr_valid pulses with instr_pc 0x0, 0x4, 0x8, 3 cycles apart.
- stall=1 for 4 cycles while instr_pc=0x4 -> instr_valid and instr_pc=0x4 held all 4 cycles; next request addr 0x8 only after stall drops.
- Redirect base=0x100, offset=0xFFFF_FFF0 (i.e. -16) while in WAIT -> in-flight response discarded (no instr_valid), next imem_addr=0xF0.
- jalr redirect base=0x201, offset=0x3 -> target 0x204, accepted. Base=0x202, offset=0 -> misalign_err pulse, pc unchanged.
- Redirect coincident with request handshake at addr 0x8, target 0x40 -> the following response dropped; next request addr=0x40; first instr_pc=0x40.
- rst_n low for 1 cycle while in WAIT, then a late imem_rsp_valid -> ignored; fetch restarts at RESET_VECTOR. Separately, pc=0xFFFF_FFFC increments to 0x0.

Source files
------------

// File: rtl/pc_fetch_pkg.sv
// ============================================================================
// pc_fetch_pkg : shared defaults and state encoding for the fetch sequencer
// Revision     : 1.0
// ============================================================================
`default_nettype none

package pc_fetch_pkg;

  localparam int unsigned DEFAULT_XLEN         = 32;
  localparam int unsigned DEFAULT_PC_INC       = 4;
  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } fetch_state_t;

endpackage

`default_nettype wire

// File: rtl/pc_add32.sv
// ============================================================================
// pc_add32 : combinational modular adder shared by PC increment and redirect
// Revision : 1.0
// ============================================================================
`default_nettype none

module pc_add32 #(
  parameter int unsigned XLEN = 32
) (
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] sum
);

  assign sum = a + b;

endmodule

`default_nettype wire

// File: rtl/pc_fetch_sequencer.sv
// ============================================================================
// pc_fetch_sequencer : owns the PC and sequences instruction fetch requests
// Revision           : 1.0
// ============================================================================
`default_nettype none

module pc_fetch_sequencer
  import pc_fetch_pkg::*;
#(
  parameter int unsigned     XLEN         = DEFAULT_XLEN,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int unsigned     PC_INC       = DEFAULT_PC_INC
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  output logic            instr_valid,
  output logic [XLEN-1:0] instr_pc,
  input  logic            stall,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_base,
  input  logic [XLEN-1:0] redirect_offset,
  input  logic            redirect_jalr,
  output logic            misalign_err
);

  fetch_state_t    state, state_nxt;
  logic [XLEN-1:0] pc, pc_nxt;
  logic            kill, kill_nxt;
  logic            misalign_nxt;

  logic [XLEN-1:0] add_a, add_b, add_sum, target;
  logic            redir_seen, redir_take;

  assign add_a = redirect_valid ? redirect_base   : pc;
  assign add_b = redirect_valid ? redirect_offset : XLEN'(PC_INC);

  pc_add32 #(.XLEN(XLEN)) u_add (
    .a   (add_a),
    .b   (add_b),
    .sum (add_sum)
  );

  assign target     = redirect_jalr ? {add_sum[XLEN-1:1], 1'b0} : add_sum;
  assign redir_seen = redirect_valid && (state != BOOT);
  assign redir_take = redir_seen && (target[1:0] == 2'b00);

  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    kill_nxt     = kill;
    misalign_nxt = redir_seen && (target[1:0] != 2'b00);
    if (redir_take) pc_nxt = target;
    case (state)
      BOOT: state_nxt = REQ;
      REQ: begin
        if (imem_req_ready) begin
          state_nxt = WAIT;
          kill_nxt  = redir_take;
        end
      end
      WAIT: begin
        if (imem_rsp_valid) begin
          state_nxt = (kill || redir_take) ? REQ : OUT;
          kill_nxt  = 1'b0;
        end else if (redir_take) begin
          kill_nxt  = 1'b1;
        end
      end
      OUT: begin
        // A rejected redirect still owns the adder this cycle, so the increment waits.
        if (redir_take) begin
          state_nxt = REQ;
        end else if (!stall && !redirect_valid) begin
          pc_nxt    = add_sum;
          state_nxt = REQ;
        end
      end
      default: state_nxt = BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= BOOT;
      pc           <= RESET_VECTOR;
      kill         <= 1'b0;
      misalign_err <= 1'b0;
    end else begin
      state        <= state_nxt;
      pc           <= pc_nxt;
      kill         <= kill_nxt;
      misalign_err <= misalign_nxt;
    end
  end

  assign imem_req_valid = (state == REQ);
  assign imem_addr      = pc;
  assign instr_valid    = (state == OUT);
  assign instr_pc       = instr_valid ? pc : '0;

endmodule

`default_nettype wire
